// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath.
// Holds the default widths that the MAC and the downstream aggregator must agree on,
// plus the state encoding of the neuron MAC controller.
package nn_pkg;

  localparam int unsigned NN_DATA_W = 4;   // signed activation width
  localparam int unsigned NN_WGT_W  = 4;   // signed weight width
  localparam int unsigned NN_ACC_W  = 12;  // accumulator / aggregator width

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StAcc  = ST_ACC,
    StOut  = ST_OUT
  } state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational multiply-accumulate step: acc_i + sign_extend(x_i * w_i).
// Optional macro NEURON_MAC_SAT_EN: when defined the result clamps to the signed
// ACC_W range; when undefined it wraps modulo 2^ACC_W.
// Ports:
//   acc_i  current signed accumulator
//   x_i    signed activation
//   w_i    signed weight
//   sum_o  updated signed accumulator value
module mac_sat_add #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned WGT_W  = 4,
  parameter int unsigned ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [WGT_W-1:0]  w_i,
  output logic [ACC_W-1:0]  sum_o
);

  localparam int unsigned PW = DATA_W + WGT_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic        [ACC_W-1:0] raw_sum;

  // Full-width product always fits in PW bits, so the truncated product is exact.
  assign prod     = PW'($signed(x_i)) * PW'($signed(w_i));
  assign prod_ext = ACC_W'(prod);
  assign raw_sum  = acc_i + prod_ext;

`ifdef NEURON_MAC_SAT_EN
  localparam logic [ACC_W-1:0] SatMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SatMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf;
  // Overflow only when both operands share a sign and the result flips it.
  assign ovf = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);

  always_comb begin
    sum_o = raw_sum;
    if (ovf) begin
      sum_o = acc_i[ACC_W-1] ? SatMin : SatMax;
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/neuron_mac.sv
// One neuron pre-activation: bias + sum over N_IN of x_in * w_in, delivered through a
// valid/ready handshake. Synchronous active-low reset. Optional macro NEURON_MAC_SAT_EN
// selects saturating accumulation (see mac_sat_add).
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start, bias       begin a neuron in IDLE, bias sampled with start
//   in_valid, x_in, w_in  one term per cycle while accumulating
//   busy              high while accumulating or holding a result
//   out_valid, out_ready, mac_out  result handshake
module neuron_mac import nn_pkg::*; #(
  parameter int unsigned DATA_W = NN_DATA_W,
  parameter int unsigned WGT_W  = NN_WGT_W,
  parameter int unsigned ACC_W  = NN_ACC_W,
  parameter int unsigned N_IN   = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic [WGT_W-1:0]  w_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  mac_out
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_IN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mac_out_q, mac_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [ACC_W-1:0] sum;
  logic             last_term;

  mac_sat_add #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i (acc_q),
    .x_i   (x_in),
    .w_i   (w_in),
    .sum_o (sum)
  );

  assign last_term = (state_q == StAcc) && in_valid && (cnt_q == LastCnt);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      mac_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mac_out_q   <= mac_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)     state_d = StAcc;
      StAcc:   if (last_term) state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mac_out_d = mac_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = bias;
          cnt_d = '0;
        end
      end
      StAcc: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
        end
        if (last_term) begin
          mac_out_d = sum;
        end
      end
      default: ;
    endcase
    busy_d      = (state_d != StIdle);
    out_valid_d = (state_d == StOut);
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign mac_out   = mac_out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac (N_IN=16, ACC_W=12).
module tb_neuron_mac;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bias = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  x_in = '0;
  logic [3:0]  w_in = '0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] mac_out;

  int tests = 0;
  int fails = 0;

  neuron_mac #(
    .DATA_W (4),
    .WGT_W  (4),
    .ACC_W  (12),
    .N_IN   (16),
    .CNT_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .w_in      (w_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mac_out   (mac_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    bias_v;
    int    x_v;
    int    w_v;
    int    exp_v;
    string name;
  } vec_t;

  vec_t vecs[4];

  // Apply inputs, take the edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int smac();
    return int'($signed(mac_out));
  endfunction

  task automatic run_neuron(input int bias_v, input int x_v, input int w_v, input int exp_v,
                            input string name);
    // in_valid pulses in IDLE must not start or disturb anything
    in_valid = 1'b1; x_in = 4'd7; w_in = 4'd7;
    tick();
    tick();
    in_valid = 1'b0;
    check({name, " idle_busy"}, int'(busy), 0);
    start = 1'b1; bias = 12'(bias_v);
    tick();
    start = 1'b0; bias = 12'(0);
    check({name, " busy_after_start"}, int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; x_in = 4'(x_v); w_in = 4'(w_v);
      tick();
      if (i < N - 1) check({name, " early_valid"}, int'(out_valid), 0);
    end
    in_valid = 1'b0;
    check({name, " out_valid"}, int'(out_valid), 1);
    check({name, " mac_out"}, smac(), exp_v);
    check({name, " busy_out"}, int'(busy), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid_drop"}, int'(out_valid), 0);
    check({name, " busy_drop"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{bias_v: 0,    x_v: 7,  w_v: 7,  exp_v: 784,  name: "basic"};
    vecs[1] = '{bias_v: -100, x_v: -3, w_v: 5,  exp_v: -340, name: "signs"};
`ifdef NEURON_MAC_SAT_EN
    vecs[2] = '{bias_v: 1100, x_v: -8, w_v: -8, exp_v: 2047, name: "overflow"};
`else
    vecs[2] = '{bias_v: 1100, x_v: -8, w_v: -8, exp_v: -1972, name: "overflow"};
`endif
    vecs[3] = '{bias_v: 0,    x_v: 0,  w_v: 5,  exp_v: 0,    name: "zero"};

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("reset mac_out", smac(), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b1;
    tick();

    foreach (vecs[k]) begin
      run_neuron(vecs[k].bias_v, vecs[k].x_v, vecs[k].w_v, vecs[k].exp_v, vecs[k].name);
    end
    check("signs msb", int'(vecs[1].exp_v < 0), 1);

    // Stalled input stream and backpressured output: 10 + 16*6 = 106
    start = 1'b1; bias = 12'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; x_in = 4'd2; w_in = 4'd3;
      tick();
      in_valid = 1'b0; x_in = 4'd7; w_in = 4'd7;
      if (i < N - 1) begin
        tick();
        check("stall early_valid", int'(out_valid), 0);
      end
    end
    check("stall out_valid", int'(out_valid), 1);
    check("stall mac_out", smac(), 106);
    for (int c = 0; c < 5; c++) begin
      start    = (c % 2 == 0);
      in_valid = (c % 2 == 1);
      tick();
      check("backpressure out_valid", int'(out_valid), 1);
      check("backpressure mac_out", smac(), 106);
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("handshake out_valid", int'(out_valid), 0);
    check("handshake busy", int'(busy), 0);
    // out_ready with nothing pending has no effect
    tick();
    out_ready = 1'b0;
    check("idle out_ready busy", int'(busy), 0);
    check("idle out_ready valid", int'(out_valid), 0);

    // Reset mid-operation
    start = 1'b1; bias = 12'd999;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; x_in = 4'd5; w_in = 4'd5;
      tick();
    end
    in_valid = 1'b0;
    check("midop busy", int'(busy), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midop reset mac_out", smac(), 0);
    check("midop reset out_valid", int'(out_valid), 0);
    check("midop reset busy", int'(busy), 0);
    tick();
    check("midop idle busy", int'(busy), 0);
    run_neuron(5, 1, 1, 21, "fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
